buzzer_tone_driver: RTL and testbench
=====================================

BUZZER_TONE_DRIVER -- requirements
Module: buzzer_tone_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-002 Port `clk`  in  1  — system clock; all state changes on its rising edge.
REQ-003 Port `rst_n`  in  1  — asynchronous active-low reset.
REQ-004 Port `ena`  in  1  — when 0, every register holds its value.
REQ-005 Port `buzz_req`  in  3  — level alarm requests from the upstream sensor stage; bit0 = zone 1, bit1 = zone 2, bit2 = zone 3.
REQ-006 Port `clr_count`  in  1  — synchronous clear of `event_count`.
REQ-007 Port `tone_out`  out  1  — square-wave drive to the piezo.
REQ-008 Port `active_zone`  out  2  — 0 = none; 1..3 = zone currently latched.
REQ-009 Port `busy`  out  1  — 1 whenever the state is not IDLE.
REQ-010 Port `event_count`  out  8  — number of accepted alarms, saturating.
REQ-011 Parameter HP1, default 4 — zone 1 half-period in clk cycles; legal range 1..255.
REQ-012 Parameter HP2, default 6 — zone 2 half-period; legal range 1..255.
REQ-013 Parameter HP3, default 10 — zone 3 half-period; legal range 1..255.
REQ-014 Parameter GAP_LEN, default 3 — silent gap length in cycles after a tone; legal range 1..255.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, TONE, GAP. All rules in REQ-016..REQ-024 apply only on edges where `ena` = 1.
REQ-016 IDLE, `buzz_req` != 0: on that edge the block SHALL
- latch the zone by fixed priority (bit0 > bit1 > bit2);
- set `tone_out` = 1 and the half-period counter to HPz-1;
- set `active_zone` = z and `busy` = 1;
- increment `event_count`;
- enter TONE.
REQ-017 IDLE, `buzz_req` == 0: the block SHALL stay in IDLE with `tone_out` = 0, `active_zone` = 0, `busy` = 0.
REQ-018 TONE, latched request bit still 1:
- counter == 0: toggle `tone_out` and reload HPz-1;
- otherwise: decrement the counter.
- Result: `tone_out` is high HPz cycles, low HPz cycles, period 2·HPz.
REQ-019 TONE, latched request bit == 0: on that edge the block SHALL force `tone_out` = 0, load the counter with GAP_LEN-1, and enter GAP. The current half-period is not completed.
REQ-020 In TONE, changes on non-latched `buzz_req` bits SHALL be ignored; there is no preemption, even by a higher-priority zone.
REQ-021 GAP: `tone_out` = 0, `busy` = 1, and `active_zone` holds the latched zone.
- counter == 0: enter IDLE with `active_zone` = 0 and `busy` = 0;
- otherwise: decrement the counter.
- GAP SHALL last exactly GAP_LEN cycles.
REQ-022 Requests present during GAP SHALL be ignored; they are re-evaluated in IDLE on the edge after GAP exits.
REQ-023 `event_count` SHALL saturate at 255; an accept at 255 leaves it at 255.
REQ-024 `clr_count` = 1 SHALL set `event_count` to 0 on that edge. A clear on the same edge as an accept SHALL give 0 (clear wins).
REQ-025 With `ena` = 0, all registers (state, counter, `tone_out`, `active_zone`, `event_count`) SHALL hold, and `clr_count` SHALL be ignored. Operation resumes from the held values when `ena` returns to 1.
REQ-026 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-027 While `rst_n` = 0, independent of `clk` and `ena`, the block SHALL asynchronously force:
- state = IDLE, counter = 0;
- `tone_out` = 0, `active_zone` = 0, `busy` = 0, `event_count` = 0.
REQ-028 Reset asserted mid-TONE or mid-GAP SHALL abort immediately. After release, the first edge with `ena` = 1 and a nonzero `buzz_req` SHALL be accepted normally.

Verification
REQ-029 Zone 1 tone: `buzz_req` = 001 held 20 cycles → `tone_out` pattern 1111 0000 1111 0000 1111, `active_zone` = 1, `event_count` = 1.
REQ-030 Zone 2 release: `buzz_req` = 010 held 8 cycles, then 000 → `tone_out` = 0 on the drop edge, `busy` = 1 for 3 further cycles, then IDLE with `active_zone` = 0.
REQ-031 Priority and no preemption: `buzz_req` = 111 → zone 1 with HP 4. Change to 110 → GAP (3 cycles), then IDLE, then zone 2 accepted with HP 6; `event_count` = 2.
REQ-032 Saturation and clear: 300 accepted alarms → `event_count` = 255. `clr_count` on the same edge as an accept → `event_count` = 0.
REQ-033 Enable freeze: `ena` = 0 for 5 cycles in mid-half-period of zone 3 → `tone_out` and `active_zone` unchanged. After `ena` = 1, the remaining half-period length is exactly what was left.
REQ-034 Asynchronous reset: `rst_n` pulsed low between clock edges during TONE → all outputs 0 before the next edge; `event_count` = 0.

Source files
------------

// File: rtl/buzzer_tone_driver_if.sv
// Purpose: bundles the alarm request/control inputs and the tone/status
//          outputs of buzzer_tone_driver into one port.
// Ports:   ena, buzz_req[2:0], clr_count (to driver); tone_out,
//          active_zone[1:0], busy, event_count[7:0] (from driver).
interface buzzer_tone_driver_if;
  logic       ena;
  logic [2:0] buzz_req;
  logic       clr_count;
  logic       tone_out;
  logic [1:0] active_zone;
  logic       busy;
  logic [7:0] event_count;

  // master: the stage issuing requests; slave: the tone driver itself
  modport master (
    output ena, buzz_req, clr_count,
    input  tone_out, active_zone, busy, event_count
  );
  modport slave (
    input  ena, buzz_req, clr_count,
    output tone_out, active_zone, busy, event_count
  );
endinterface

// File: rtl/buzzer_tone_driver.sv
// Purpose: piezo square-wave driver; latches the highest-priority alarm zone,
//          toggles at that zone's half-period until the request drops, then
//          holds a fixed silent gap. Counts accepted alarms (saturating).
// Ports:   clk, rst_n (async active-low), bus (slave side of the interface).
//          All outputs registered; ena=0 freezes every register.
module buzzer_tone_driver #(
  parameter int HP1     = 4,
  parameter int HP2     = 6,
  parameter int HP3     = 10,
  parameter int GAP_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  buzzer_tone_driver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam logic [7:0] HP1_M1 = 8'(HP1 - 1);
  localparam logic [7:0] HP2_M1 = 8'(HP2 - 1);
  localparam logic [7:0] HP3_M1 = 8'(HP3 - 1);
  localparam logic [7:0] GAP_M1 = 8'(GAP_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tone_q, tone_d;
  logic [1:0] zone_q, zone_d;
  logic       busy_q, busy_d;
  logic [7:0] evt_q, evt_d;
  logic       accept;
  logic [1:0] acc_zone;
  logic       req_bit;

  function automatic logic [7:0] reload(input logic [1:0] z);
    case (z)
      2'd1:    reload = HP1_M1;
      2'd2:    reload = HP2_M1;
      default: reload = HP3_M1;
    endcase
  endfunction

  // Fixed priority: zone 1 beats zone 2 beats zone 3
  always_comb begin
    acc_zone = 2'd0;
    if (bus.buzz_req[0])      acc_zone = 2'd1;
    else if (bus.buzz_req[1]) acc_zone = 2'd2;
    else if (bus.buzz_req[2]) acc_zone = 2'd3;
  end

  // Request bit of the zone already latched; other bits are ignored in TONE
  always_comb begin
    case (zone_q)
      2'd1:    req_bit = bus.buzz_req[0];
      2'd2:    req_bit = bus.buzz_req[1];
      2'd3:    req_bit = bus.buzz_req[2];
      default: req_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tone_d  = tone_q;
    zone_d  = zone_q;
    evt_d   = evt_q;
    accept  = 1'b0;
    if (bus.ena) begin
      case (state_q)
        IDLE: begin
          tone_d = 1'b0;
          zone_d = 2'd0;
          if (acc_zone != 2'd0) begin
            accept  = 1'b1;
            zone_d  = acc_zone;
            tone_d  = 1'b1;
            cnt_d   = reload(acc_zone);
            state_d = TONE;
          end
        end
        TONE: begin
          if (req_bit) begin
            if (cnt_q == 8'd0) begin
              tone_d = ~tone_q;
              cnt_d  = reload(zone_q);
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end else begin
            // request dropped: cut the current half-period short
            tone_d  = 1'b0;
            cnt_d   = GAP_M1;
            state_d = GAP;
          end
        end
        GAP: begin
          tone_d = 1'b0;
          if (cnt_q == 8'd0) begin
            zone_d  = 2'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          tone_d  = 1'b0;
          zone_d  = 2'd0;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      endcase
      // clear wins over a simultaneous accept
      if (bus.clr_count)                 evt_d = 8'd0;
      else if (accept && evt_q != 8'hFF) evt_d = evt_q + 8'd1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      tone_q  <= 1'b0;
      zone_q  <= 2'd0;
      busy_q  <= 1'b0;
      evt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      zone_q  <= zone_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.tone_out    = tone_q;
  assign bus.active_zone = zone_q;
  assign bus.busy        = busy_q;
  assign bus.event_count = evt_q;

endmodule

// File: tb/tb_buzzer_tone_driver.sv
// Purpose: self-checking bench for buzzer_tone_driver; expected outputs are
//          queued as each edge is driven and popped/compared after the edge.
// Ports:   none (top-level bench; default parameters HP 4/6/10, gap 3).
module tb_buzzer_tone_driver;

  typedef struct packed {
    logic       tone;
    logic [1:0] zone;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  localparam int GAP = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];
  exp_t got, want;

  buzzer_tone_driver_if bus();

  buzzer_tone_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input bit t, input int z, input bit b, input int c);
    exp_t e;
    e.tone = t;
    e.zone = 2'(z);
    e.busy = b;
    e.cnt  = 8'(c);
    return e;
  endfunction

  function automatic exp_t sample();
    return mk(bus.tone_out, int'(bus.active_zone), bus.busy, int'(bus.event_count));
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("tone=%0b zone=%0d busy=%0b count=%0d", e.tone, e.zone, e.busy, e.cnt);
  endfunction

  // Drive inputs, queue the expected post-edge outputs, advance one edge.
  task automatic drive_edge(input logic [2:0] req, input logic clr, input logic en, input exp_t e);
    bus.buzz_req  = req;
    bus.clr_count = clr;
    bus.ena       = en;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.buzz_req  = 3'b000;
    bus.clr_count = 1'b0;
    bus.ena       = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.buzz_req  = 3'b000;
    bus.clr_count = 1'b0;
    bus.ena       = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back(mk(0, 0, 0, 0));
    got = sample(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset_state: got %s want %s", fmt(got), fmt(want)); end
    // requests while held in reset must be ignored
    for (int i = 0; i < 2; i++) begin
      drive_edge(3'b111, 1'b0, 1'b1, mk(0, 0, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_hold: got %s want %s", fmt(got), fmt(want)); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zone1();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive_edge(3'b001, 1'b0, 1'b1, mk(((k / 4) % 2) == 0, 1, 1, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL zone1_tone k=%0d: got %s want %s", k, fmt(got), fmt(want)); end
    end
    for (int g = 0; g <= GAP; g++) begin
      drive_edge(3'b000, 1'b0, 1'b1, (g < GAP) ? mk(0, 1, 1, 1) : mk(0, 0, 0, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL zone1_gap g=%0d: got %s want %s", g, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_zone2_release();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive_edge(3'b010, 1'b0, 1'b1, mk(((k / 6) % 2) == 0, 2, 1, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL zone2_tone k=%0d: got %s want %s", k, fmt(got), fmt(want)); end
    end
    for (int g = 0; g <= GAP; g++) begin
      drive_edge(3'b000, 1'b0, 1'b1, (g < GAP) ? mk(0, 2, 1, 1) : mk(0, 0, 0, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL zone2_release g=%0d: got %s want %s", g, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_priority();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_edge(3'b111, 1'b0, 1'b1, mk(((k / 4) % 2) == 0, 1, 1, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL prio_zone1 k=%0d: got %s want %s", k, fmt(got), fmt(want)); end
    end
    // zone 1 drops, zone 2 still requesting: no preemption, full gap, idle edge
    for (int g = 0; g <= GAP; g++) begin
      drive_edge(3'b110, 1'b0, 1'b1, (g < GAP) ? mk(0, 1, 1, 1) : mk(0, 0, 0, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL prio_gap g=%0d: got %s want %s", g, fmt(got), fmt(want)); end
    end
    for (int k = 0; k < 12; k++) begin
      drive_edge(3'b110, 1'b0, 1'b1, mk(((k / 6) % 2) == 0, 2, 1, 2));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL prio_zone2 k=%0d: got %s want %s", k, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_saturation();
    int c;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      c = (n > 255) ? 255 : n;
      drive_edge(3'b001, 1'b0, 1'b1, mk(1, 1, 1, c));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL sat_accept n=%0d: got %s want %s", n, fmt(got), fmt(want)); end
      for (int g = 0; g <= GAP; g++) begin
        drive_edge(3'b000, 1'b0, 1'b1, (g < GAP) ? mk(0, 1, 1, c) : mk(0, 0, 0, c));
        got = sample(); want = sb.pop_front(); total++;
        if (got !== want) begin bad++; $display("FAIL sat_gap n=%0d g=%0d: got %s want %s", n, g, fmt(got), fmt(want)); end
      end
    end
    drive_edge(3'b001, 1'b1, 1'b1, mk(1, 1, 1, 0));
    got = sample(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL clear_on_accept: got %s want %s", fmt(got), fmt(want)); end
    drive_edge(3'b001, 1'b0, 1'b1, mk(1, 1, 1, 0));
    got = sample(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL clear_after: got %s want %s", fmt(got), fmt(want)); end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_edge(3'b100, 1'b0, 1'b1, mk(1, 3, 1, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL freeze_pre k=%0d: got %s want %s", k, fmt(got), fmt(want)); end
    end
    // frozen: dropped request and clear must both be ignored
    for (int f = 0; f < 5; f++) begin
      drive_edge(3'b000, 1'b1, 1'b0, mk(1, 3, 1, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL freeze_hold f=%0d: got %s want %s", f, fmt(got), fmt(want)); end
    end
    for (int k = 4; k < 20; k++) begin
      drive_edge(3'b100, 1'b0, 1'b1, mk(((k / 10) % 2) == 0, 3, 1, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL freeze_resume k=%0d: got %s want %s", k, fmt(got), fmt(want)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive_edge(3'b010, 1'b0, 1'b1, mk(1, 2, 1, 1));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL areset_pre k=%0d: got %s want %s", k, fmt(got), fmt(want)); end
    end
    #3;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(0, 0, 0, 0));
    got = sample(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL async_reset: got %s want %s", fmt(got), fmt(want)); end
    #1;
    rst_n = 1'b1;
    drive_edge(3'b001, 1'b0, 1'b1, mk(1, 1, 1, 1));
    got = sample(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL post_reset_accept: got %s want %s", fmt(got), fmt(want)); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zone1();
    test_zone2_release();
    test_priority();
    test_saturation();
    test_enable_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
